operand_entry: RTL and testbench

Front-end stage feeding the GCD core on the DE0-Nano-SoC board. It debounces the two push-buttons and assembles two signed 8-bit operands from nibbles entered on SW[3:0], low nibble first. It converts each operand to unsigned magnitude plus sign. It presents the pair to the downstream core over a valid/ready handshake, so the core no longer handles raw keys or sign fix-up.

---
 rtl/operand_entry_pkg.sv | 20 ++
 rtl/operand_entry_key_debounce.sv | 57 +++++
 rtl/operand_entry.sv | 117 +++++++++++
 tb/tb_operand_entry.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_entry_pkg.sv
// Shared definitions for the GCD operand entry front end:
// entry phases, default debounce length and sign/magnitude split.
package operand_entry_pkg;

  typedef enum logic [2:0] {
    A_LO    = 3'd0,
    A_HI    = 3'd1,
    B_LO    = 3'd2,
    B_HI    = 3'd3,
    PRESENT = 3'd4
  } phase_e;

  localparam int DEBOUNCE_DEFAULT = 500000;

  // {neg, magnitude}; 0x80 keeps magnitude 0x80 with neg set
  function automatic logic [8:0] sign_mag(input logic [7:0] v);
    sign_mag = {v[7], v[7] ? (~v + 8'd1) : v};
  endfunction

endpackage

// File: rtl/operand_entry_key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter
// and a one-cycle pulse on the debounced press (1->0) edge.
module key_debounce
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 20
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic key_raw,
  output logic key_level,
  output logic press
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_q;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_flip;

  assign w_diff = r_sync2 != r_stable;
  assign w_flip = w_diff && (r_cnt == LAST);

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_stable   <= 1'b1;
      r_stable_q <= 1'b1;
      r_press    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= key_raw;
      r_sync2    <= r_sync1;
      r_stable_q <= r_stable;
      r_press    <= r_stable_q & ~r_stable;
      if (!w_diff || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_flip) begin
        r_stable <= r_sync2;
      end
    end
  end

  assign key_level = r_stable;
  assign press     = r_press;

endmodule

// File: rtl/operand_entry.sv
// Nibble-wise entry of two signed bytes, presented downstream
// as magnitude plus sign over a valid/ready handshake.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 20
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [1:0] KEY,
  input  logic [3:0] SW,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic       a_neg,
  output logic       b_neg,
  output logic       ops_valid,
  input  logic       ops_ready,
  output logic [2:0] phase
);

  logic       w_load;
  logic       w_clr;
  logic [1:0] w_unused_lvl;
  logic [8:0] w_am;
  logic [8:0] w_bm;

  phase_e     r_state;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_op_a;
  logic [7:0] r_op_b;
  logic       r_a_neg;
  logic       r_b_neg;
  logic       r_valid;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_load (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .key_raw  (KEY[1]),
    .key_level(w_unused_lvl[1]),
    .press    (w_load)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_clr (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .key_raw  (KEY[0]),
    .key_level(w_unused_lvl[0]),
    .press    (w_clr)
  );

  // B's high nibble is taken straight from SW on the final load
  assign w_am = sign_mag(r_a);
  assign w_bm = sign_mag({SW, r_b[3:0]});

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      r_state <= A_LO;
      r_a     <= '0;
      r_b     <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_a_neg <= 1'b0;
      r_b_neg <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_clr) begin
      r_state <= A_LO;
      r_a     <= '0;
      r_b     <= '0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        A_LO: if (w_load) begin
          r_a[3:0] <= SW;
          r_state  <= A_HI;
        end
        A_HI: if (w_load) begin
          r_a[7:4] <= SW;
          r_state  <= B_LO;
        end
        B_LO: if (w_load) begin
          r_b[3:0] <= SW;
          r_state  <= B_HI;
        end
        B_HI: if (w_load) begin
          r_b[7:4] <= SW;
          r_state  <= PRESENT;
          r_valid  <= 1'b1;
          r_op_a   <= w_am[7:0];
          r_a_neg  <= w_am[8];
          r_op_b   <= w_bm[7:0];
          r_b_neg  <= w_bm[8];
        end
        PRESENT: if (ops_ready) begin
          r_state <= A_LO;
          r_valid <= 1'b0;
        end
        default: r_state <= A_LO;
      endcase
    end
  end

  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign a_neg     = r_a_neg;
  assign b_neg     = r_b_neg;
  assign ops_valid = r_valid;
  assign phase     = r_state;

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry with a short debounce,
// reference values from plain two's-complement arithmetic.
module tb_operand_entry;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] key = 2'b11;
  logic [3:0] sw = 4'h0;
  logic       ready = 1'b0;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       a_neg;
  logic       b_neg;
  logic       ops_valid;
  logic [2:0] phase;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_entry #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .KEY      (key),
    .SW       (sw),
    .op_a     (op_a),
    .op_b     (op_b),
    .a_neg    (a_neg),
    .b_neg    (b_neg),
    .ops_valid(ops_valid),
    .ops_ready(ready),
    .phase    (phase)
  );

  function automatic logic [7:0] mag_of(input int v);
    return (v >= 128) ? 8'(256 - v) : 8'(v);
  endfunction

  function automatic logic neg_of(input int v);
    return v >= 128;
  endfunction

  function automatic logic [21:0] obs();
    return {phase, ops_valid, op_a, op_b, a_neg, b_neg};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clean press of the masked keys; samples phase/valid around the
  // expected action edge (D+3 edges after the first low sample).
  task automatic key_press(input logic [1:0] mask,
                           output logic [2:0] ph_early,
                           output logic [2:0] ph_at,
                           output logic v_early,
                           output logic v_at);
    key = key & ~mask;
    for (int i = 0; i <= D + 5; i++) begin
      @(posedge clk);
      #1;
      if (i == D + 2) begin
        ph_early = phase;
        v_early  = ops_valid;
      end
      if (i == D + 3) begin
        ph_at = phase;
        v_at  = ops_valid;
      end
    end
    key = key | mask;
    tick(D + 6);
  endtask

  task automatic enter_pair(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] n[4];
    logic [2:0] p0, p1;
    logic       v0, v1;
    n[0] = a[3:0];
    n[1] = a[7:4];
    n[2] = b[3:0];
    n[3] = b[7:4];
    for (int k = 0; k < 4; k++) begin
      sw = n[k];
      key_press(2'b10, p0, p1, v0, v1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if (obs() !== 22'h0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs(), 22'h0);
    end
    rst_n = 1'b1;
    tick(D + 6);
  endtask

  task automatic test_clean_entry();
    logic [3:0] n[4];
    logic [2:0] p0, p1;
    logic       v0, v1;
    logic [21:0] exp;
    n[0] = 4'h4;
    n[1] = 4'h1;
    n[2] = 4'hC;
    n[3] = 4'h0;
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sw = n[k];
      key_press(2'b10, p0, p1, v0, v1);
      checks++;
      if (p0 !== 3'(k) || p1 !== 3'(k + 1)) begin
        failures++;
        $display("FAIL entry_phase%0d got=%0d/%0d exp=%0d/%0d",
                 k, p0, p1, k, k + 1);
      end
      if (k == 3) begin
        checks++;
        if (v0 !== 1'b0 || v1 !== 1'b1) begin
          failures++;
          $display("FAIL entry_valid_latency got=%b/%b exp=0/1", v0, v1);
        end
      end
    end
    exp = {3'd4, 1'b1, 8'h14, 8'h0C, 1'b0, 1'b0};
    checks++;
    if (obs() !== exp) begin
      failures++;
      $display("FAIL entry_operands got=%h exp=%h", obs(), exp);
    end
  endtask

  task automatic test_handshake();
    logic [21:0] exp;
    int bad;
    exp = {3'd4, 1'b1, 8'h14, 8'h0C, 1'b0, 1'b0};
    bad = 0;
    sw = 4'h7;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) key[1] = 1'b0;
      if (i == 12) key[1] = 1'b1;
      @(posedge clk);
      #1;
      if (obs() !== exp) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_present bad_cycles=%0d got=%h exp=%h",
               bad, obs(), exp);
    end
    tick(D + 6);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    exp = {3'd0, 1'b0, 8'h14, 8'h0C, 1'b0, 1'b0};
    checks++;
    if (obs() !== exp) begin
      failures++;
      $display("FAIL handshake got=%h exp=%h", obs(), exp);
    end
    tick(2);
  endtask

  task automatic test_values();
    logic [7:0]  av[8];
    logic [7:0]  bv[8];
    logic [21:0] exp;
    logic        pre;
    av[0] = 8'hF6;
    bv[0] = 8'h80;
    av[1] = 8'h00;
    bv[1] = 8'h7F;
    for (int k = 2; k < 8; k++) begin
      av[k] = 8'($urandom);
      bv[k] = 8'($urandom);
    end
    for (int k = 0; k < 8; k++) begin
      pre   = (k >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      ready = pre;
      enter_pair(av[k], bv[k]);
      exp = {pre ? 3'd0 : 3'd4, ~pre,
             mag_of(int'(av[k])), mag_of(int'(bv[k])),
             neg_of(int'(av[k])), neg_of(int'(bv[k]))};
      checks++;
      if (obs() !== exp) begin
        failures++;
        $display("FAIL values%0d a=%h b=%h got=%h exp=%h",
                 k, av[k], bv[k], obs(), exp);
      end
      if (!pre) begin
        tick($urandom_range(0, 5));
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        exp[21:18] = 4'b0000;
        checks++;
        if (obs() !== exp) begin
          failures++;
          $display("FAIL values_hs%0d got=%h exp=%h", k, obs(), exp);
        end
      end
      ready = 1'b0;
      tick(2);
    end
  endtask

  task automatic test_bounce();
    int bad;
    logic [2:0] want;
    bad = 0;
    sw = 4'h9;
    key[1] = 1'b0;
    tick(3);
    key[1] = 1'b1;
    tick(2);
    key[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      want = (i >= 7) ? 3'd1 : 3'd0;
      if (phase !== want) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bounce_timing bad_cycles=%0d phase=%0d", bad, phase);
    end
    key[1] = 1'b1;
    tick(D + 6);
    checks++;
    if (phase !== 3'd1 || dut.r_a[3:0] !== 4'h9) begin
      failures++;
      $display("FAIL bounce_single got=%0d/%h exp=1/9",
               phase, dut.r_a[3:0]);
    end
  endtask

  task automatic test_clear();
    logic [2:0]  p0, p1;
    logic        v0, v1;
    logic [21:0] exp;
    sw = 4'h5;
    key_press(2'b10, p0, p1, v0, v1);
    key_press(2'b01, p0, p1, v0, v1);
    checks++;
    if (p0 !== 3'd2 || p1 !== 3'd0 ||
        dut.r_a !== 8'h00 || dut.r_b !== 8'h00) begin
      failures++;
      $display("FAIL clear_blo got=%0d/%0d a=%h b=%h exp=2/0 a=00 b=00",
               p0, p1, dut.r_a, dut.r_b);
    end
    key_press(2'b10, p0, p1, v0, v1);
    key_press(2'b10, p0, p1, v0, v1);
    key_press(2'b11, p0, p1, v0, v1);
    checks++;
    if (p0 !== 3'd2 || p1 !== 3'd0 || dut.r_a !== 8'h00) begin
      failures++;
      $display("FAIL clear_wins got=%0d/%0d a=%h exp=2/0 a=00",
               p0, p1, dut.r_a);
    end
    ready = 1'b0;
    enter_pair(8'h33, 8'hF0);
    key_press(2'b01, p0, p1, v0, v1);
    checks++;
    if (v0 !== 1'b1 || v1 !== 1'b0 || p1 !== 3'd0) begin
      failures++;
      $display("FAIL clear_present got=%b/%b/%0d exp=1/0/0", v0, v1, p1);
    end
    exp = {3'd0, 1'b0, 8'h33, 8'h10, 1'b0, 1'b1};
    checks++;
    if (obs() !== exp) begin
      failures++;
      $display("FAIL clear_hold got=%h exp=%h", obs(), exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] p0, p1;
    logic       v0, v1;
    int bad;
    logic [2:0] want;
    sw = 4'h1;
    key_press(2'b10, p0, p1, v0, v1);
    key_press(2'b10, p0, p1, v0, v1);
    key[1] = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    checks++;
    if (obs() !== 22'h0 || phase !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=%h", obs(), 22'h0);
    end
    tick(2);
    sw = 4'h5;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      want = (i >= 7) ? 3'd1 : 3'd0;
      if (phase !== want) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_held_key bad_cycles=%0d phase=%0d", bad, phase);
    end
    key[1] = 1'b1;
    tick(D + 6);
  endtask

  initial begin
    tick(1);
    test_reset();
    test_clean_entry();
    test_handshake();
    test_values();
    test_bounce();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
